// File: rtl/pulse_width_decoder.sv
// pulse_width_decoder: measures high-pulse widths on `in` and hands each one off over dav_/rfd
module pulse_width_decoder #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  input  logic         rfd,
  output logic         dav_,
  output logic [W-1:0] data,
  output logic         overrun
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COUNT    = 3'd1;
  localparam logic [2:0] OFFER    = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] WAIT_RFD = 3'd4;
  logic [2:0]   state_q, state_d;
  logic [W-1:0] count_q, count_d, data_q, data_d;
  logic         in_q, dav_q, dav_d, overrun_q, overrun_d, rise, busy;
  assign rise = in & ~in_q;
  // a new pulse while a result is still being handed off is lost, not queued
  assign busy = (state_q == OFFER) | (state_q == WAIT_ACK) | (state_q == WAIT_RFD);
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    dav_d     = dav_q;
    overrun_d = overrun_q | (rise & busy);
    case (state_q)
      IDLE: begin
        count_d = rise ? {{(W-1){1'b0}}, 1'b1} : count_q;
        state_d = rise ? COUNT : IDLE;
      end
      COUNT: begin
        count_d = in ? ((count_q == '1) ? count_q : count_q + 1'b1) : count_q;
        data_d  = in ? data_q : count_q;
        dav_d   = in ? dav_q : ~rfd;
        state_d = in ? COUNT : (rfd ? WAIT_ACK : OFFER);
      end
      OFFER: begin
        dav_d   = ~rfd;
        state_d = rfd ? WAIT_ACK : OFFER;
      end
      WAIT_ACK: begin
        dav_d   = ~rfd;
        state_d = rfd ? WAIT_ACK : WAIT_RFD;
      end
      WAIT_RFD: state_d = rfd ? IDLE : WAIT_RFD;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q      <= 1'b1;
      state_q   <= IDLE;
      count_q   <= '0;
      data_q    <= '0;
      dav_q     <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      in_q      <= in;
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      dav_q     <= dav_d;
      overrun_q <= overrun_d;
    end
  end
  assign dav_    = dav_q;
  assign data    = data_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_pulse_width_decoder.sv
// tb_pulse_width_decoder: directed checks of width measurement, handshake, overrun and reset
module tb_pulse_width_decoder;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in    = 1'b0;
  logic       rfd   = 1'b1;
  logic       dav_;
  logic [7:0] data;
  logic       overrun;
  int         checks = 0;
  int         errors = 0;

  pulse_width_decoder #(.W(8)) dut (
    .clock(clock), .reset(reset), .in(in), .rfd(rfd),
    .dav_(dav_), .data(data), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // drives a w-cycle pulse then the falling cycle; returns just after the fall edge
  task automatic pulse(input int w);
    in = 1'b1;
    tick(w);
    in = 1'b0;
    tick();
  endtask

  // completes the handshake from WAIT_ACK: drop rfd, see dav_ rise, re-raise rfd
  task automatic ack(input int w);
    rfd = 1'b0;
    tick();
    check("ack_dav_high", {31'd0, dav_}, 1);
    check("ack_data_held", {24'd0, data}, w);
    rfd = 1'b1;
    tick();
  endtask

  initial begin
    int widths[5] = '{1, 2, 254, 255, 300};
    int exps[5]   = '{1, 2, 254, 255, 255};
    int d1, d2, w;
    // 1: reset and a 15-cycle pulse
    tick(3);
    reset = 1'b0;
    check("rst_dav", {31'd0, dav_}, 1);
    check("rst_data", {24'd0, data}, 0);
    check("rst_ovr", {31'd0, overrun}, 0);
    tick(2);
    pulse(15);
    check("p15_dav", {31'd0, dav_}, 0);
    check("p15_data", {24'd0, data}, 15);
    ack(15);
    // 2: boundary widths
    for (int i = 0; i < 5; i++) begin
      tick(2);
      pulse(widths[i]);
      check("bnd_dav", {31'd0, dav_}, 0);
      check("bnd_data", {24'd0, data}, exps[i]);
      ack(exps[i]);
    end
    // 3: slow consumer
    tick(2);
    rfd = 1'b0;
    pulse(21);
    for (int i = 0; i < 10; i++) begin
      check("slow_dav_high", {31'd0, dav_}, 1);
      check("slow_data", {24'd0, data}, 21);
      if (i < 9) tick();
    end
    rfd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("slow_dav_low", {31'd0, dav_}, 0);
      check("slow_data_low", {24'd0, data}, 21);
    end
    ack(21);
    // 4: overrun during WAIT_ACK
    tick(2);
    pulse(12);
    check("ovr_first_dav", {31'd0, dav_}, 0);
    check("ovr_pre", {31'd0, overrun}, 0);
    pulse(7);
    check("ovr_set", {31'd0, overrun}, 1);
    check("ovr_dav_still_low", {31'd0, dav_}, 0);
    check("ovr_data", {24'd0, data}, 12);
    ack(12);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ovr_no_second", {31'd0, dav_}, 1);
    end
    pulse(9);
    check("ovr_next_dav", {31'd0, dav_}, 0);
    check("ovr_next_data", {24'd0, data}, 9);
    check("ovr_sticky", {31'd0, overrun}, 1);
    ack(9);
    // 5: reset in the middle of a 20-cycle pulse
    tick(2);
    in = 1'b1;
    tick(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ovr", {31'd0, overrun}, 0);
    for (int i = 0; i < 14; i++) begin
      tick();
      check("mid_rst_dav", {31'd0, dav_}, 1);
    end
    in = 1'b0;
    tick();
    check("mid_rst_fall_dav", {31'd0, dav_}, 1);
    tick(3);
    check("mid_rst_quiet", {31'd0, dav_}, 1);
    pulse(6);
    check("mid_rst_next_dav", {31'd0, dav_}, 0);
    check("mid_rst_next_data", {24'd0, data}, 6);
    ack(6);
    // 6: stream of 32 pulses with a randomly delayed consumer
    for (int i = 0; i < 32; i++) begin
      w  = 12 + 3 * (i % 8);
      d1 = $urandom_range(0, 8);
      d2 = $urandom_range(0, 8);
      tick(3);
      rfd = (d1 == 0);
      pulse(w);
      if (d1 > 0) begin
        check("strm_offer", {31'd0, dav_}, 1);
        tick(d1 - 1);
        rfd = 1'b1;
        tick();
      end
      check("strm_dav", {31'd0, dav_}, 0);
      check("strm_data", {24'd0, data}, w);
      tick(d2);
      check("strm_dav_hold", {31'd0, dav_}, 0);
      ack(w);
    end
    check("strm_ovr", {31'd0, overrun}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
